// File: rtl/peripheral_datos_bank.sv
// peripheral_datos_bank: parametrised sensor-data register bank on the J1 I/O bus.
//
// Holds NCH channels of DW-bit measurements. Sensor front-ends write channels through a
// valid/ready update port. The CPU reads and writes through the cs/rd/wr bus. The bank
// also keeps per-channel fresh flags, sticky overrun/bad-channel flags, a freeze snapshot
// and a level interrupt.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   d_in       bus write data
//   cs         chip select
//   addr       register address
//   rd, wr     bus read / write strobes
//   d_out      combinational bus read data (0 unless cs && rd)
//   upd_valid  sensor update request
//   upd_ch     update target channel
//   upd_data   update value
//   upd_ready  update accepted when high together with upd_valid
//   irq        registered level interrupt
//
// Address map: 0..NCH-1 channels, 2^AW-2 STATUS, 2^AW-1 CTRL, anything else reads 0.
// STATUS = {overrun, bad_ch, 0..., fresh[NCH-1:0]}; CTRL = {irq_en, wr_en, clr_all(0), freeze}.

module peripheral_datos_bank #(
    parameter int unsigned NCH       = 10,
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 4,
    parameter int unsigned INIT_BASE = 32'h30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   d_in,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          rd,
    input  logic          wr,
    output logic [15:0]   d_out,
    input  logic          upd_valid,
    input  logic [AW-1:0] upd_ch,
    input  logic [DW-1:0] upd_data,
    output logic          upd_ready,
    output logic          irq
);

    localparam logic [AW-1:0] NCH_A       = AW'(NCH);
    localparam logic [AW-1:0] STATUS_ADDR = {{(AW-1){1'b1}}, 1'b0};
    localparam logic [AW-1:0] CTRL_ADDR   = {AW{1'b1}};

    function automatic logic [DW-1:0] init_val(input int unsigned idx);
        init_val = DW'(INIT_BASE + idx);
    endfunction

    logic [DW-1:0]  live_q [NCH];
    logic [DW-1:0]  live_d [NCH];
    logic [DW-1:0]  snap_q [NCH];
    logic [DW-1:0]  snap_d [NCH];
    logic [NCH-1:0] fresh_q, fresh_d;
    logic           bad_ch_q, bad_ch_d;
    logic           overrun_q, overrun_d;
    logic           freeze_q, freeze_d;
    logic           wr_en_q, wr_en_d;
    logic           irq_en_q, irq_en_d;
    logic           rd_q;
    logic           irq_q, irq_d;

    logic           bus_rd, bus_wr, rd_edge;
    logic           addr_is_ch, ch_wr, ctrl_wr, clr_all;
    logic           upd_fire, upd_in_range;
    logic [15:0]    status_word;

    // Only bits [DW-1:0] and [3:0] of d_in are architecturally used.
    logic unused_d_in;
    assign unused_d_in = ^d_in;

    assign bus_rd       = cs && rd;
    assign bus_wr       = cs && wr;
    // Read side effects fire once per rd assertion, on its rising edge.
    assign rd_edge      = bus_rd && !rd_q;
    assign addr_is_ch   = addr < NCH_A;
    assign ch_wr        = bus_wr && addr_is_ch && wr_en_q;
    assign ctrl_wr      = bus_wr && (addr == CTRL_ADDR);
    assign clr_all      = ctrl_wr && d_in[1];
    assign upd_in_range = upd_ch < NCH_A;

    // Stall the sensor when the CPU owns the same channel this cycle or the bank is cleared,
    // so the update lands on the following cycle instead of being lost.
    assign upd_ready = !clr_all && !(ch_wr && (upd_ch == addr));
    assign upd_fire  = upd_valid && upd_ready;

    assign irq = irq_q;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            live_d[i] = live_q[i];
            snap_d[i] = snap_q[i];
        end
        fresh_d   = fresh_q;
        bad_ch_d  = bad_ch_q;
        overrun_d = overrun_q;
        freeze_d  = freeze_q;
        wr_en_d   = wr_en_q;
        irq_en_d  = irq_en_q;

        if (ctrl_wr) begin
            freeze_d = d_in[0];
            wr_en_d  = d_in[2];
            irq_en_d = d_in[3];
            // Capture only on the 0->1 transition of freeze.
            if (d_in[0] && !freeze_q) begin
                for (int i = 0; i < NCH; i++) begin
                    snap_d[i] = live_q[i];
                end
            end
        end

        if (clr_all) begin
            for (int i = 0; i < NCH; i++) begin
                live_d[i] = init_val(i);
            end
            fresh_d   = '0;
            bad_ch_d  = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (rd_edge && (addr == STATUS_ADDR)) begin
                bad_ch_d  = 1'b0;
                overrun_d = 1'b0;
            end
            // Later assignments win: an update's fresh set overrides a same-cycle read clear.
            for (int i = 0; i < NCH; i++) begin
                if (rd_edge && (addr == AW'(i))) begin
                    fresh_d[i] = 1'b0;
                end
                if (ch_wr && (addr == AW'(i))) begin
                    live_d[i] = d_in[DW-1:0];
                end
                if (upd_fire && (upd_ch == AW'(i))) begin
                    live_d[i]  = upd_data;
                    fresh_d[i] = 1'b1;
                    if (fresh_q[i]) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            if (upd_fire && !upd_in_range) begin
                bad_ch_d = 1'b1;
            end
        end
    end

    assign irq_d = irq_en_q && ((|fresh_q) || overrun_q || bad_ch_q);

    always_comb begin
        status_word            = '0;
        status_word[NCH-1:0]   = fresh_q;
        status_word[14]        = bad_ch_q;
        status_word[15]        = overrun_q;
    end

    always_comb begin
        d_out = '0;
        if (bus_rd) begin
            if (addr == STATUS_ADDR) begin
                d_out = status_word;
            end else if (addr == CTRL_ADDR) begin
                d_out = {12'd0, irq_en_q, wr_en_q, 1'b0, freeze_q};
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    if (addr == AW'(i)) begin
                        d_out = 16'(freeze_q ? snap_q[i] : live_q[i]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                live_q[i] <= init_val(i);
                snap_q[i] <= init_val(i);
            end
            fresh_q   <= '0;
            bad_ch_q  <= 1'b0;
            overrun_q <= 1'b0;
            freeze_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            irq_en_q  <= 1'b0;
            rd_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                live_q[i] <= live_d[i];
                snap_q[i] <= snap_d[i];
            end
            fresh_q   <= fresh_d;
            bad_ch_q  <= bad_ch_d;
            overrun_q <= overrun_d;
            freeze_q  <= freeze_d;
            wr_en_q   <= wr_en_d;
            irq_en_q  <= irq_en_d;
            rd_q      <= rd;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_peripheral_datos_bank.sv
// Scoreboard bench for peripheral_datos_bank (NCH=10, DW=8, AW=4, INIT_BASE=0x30).
// Stimulus pushes expected read data / signal levels into queues; a negedge monitor pops
// and compares whenever the bench presents a read or a signal check.

module tb_peripheral_datos_bank;

    logic        clk;
    logic        rst;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic        upd_valid;
    logic [3:0]  upd_ch;
    logic [7:0]  upd_data;
    logic        upd_ready;
    logic        irq;

    peripheral_datos_bank #(
        .NCH       (10),
        .DW        (8),
        .AW        (4),
        .INIT_BASE (32'h30)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .cs        (cs),
        .addr      (addr),
        .rd        (rd),
        .wr        (wr),
        .d_out     (d_out),
        .upd_valid (upd_valid),
        .upd_ch    (upd_ch),
        .upd_data  (upd_data),
        .upd_ready (upd_ready),
        .irq       (irq)
    );

    typedef struct {
        string       name;
        logic [15:0] val;
    } rd_exp_t;

    typedef struct {
        string name;
        bit    is_ready;
        logic  val;
    } sig_exp_t;

    rd_exp_t  rq[$];
    sig_exp_t sq[$];
    rd_exp_t  re;
    sig_exp_t se;
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%04h, required 0x%04h", name, got, want);
        end
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (cs && rd) begin
            if (rq.size() == 0) begin
                compare("unexpected_read", d_out, 16'hxxxx);
            end else begin
                re = rq.pop_front();
                compare(re.name, d_out, re.val);
            end
        end
        while (sq.size() > 0) begin
            se = sq.pop_front();
            compare(se.name, {15'd0, se.is_ready ? upd_ready : irq}, {15'd0, se.val});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rd(input string name, input logic [15:0] val);
        rd_exp_t e;
        e.name = name;
        e.val  = val;
        rq.push_back(e);
    endtask

    task automatic exp_sig(input string name, input bit is_ready, input logic val);
        sig_exp_t e;
        e.name     = name;
        e.is_ready = is_ready;
        e.val      = val;
        sq.push_back(e);
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [15:0] val, input string name);
        cs = 1'b1; rd = 1'b1; addr = a;
        exp_rd(name, val);
        tick();
        cs = 1'b0; rd = 1'b0;
        tick();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] data);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = data;
        tick();
        cs = 1'b0; wr = 1'b0;
        tick();
    endtask

    task automatic update(input logic [3:0] ch, input logic [7:0] data);
        bit done;
        done      = 1'b0;
        upd_valid = 1'b1; upd_ch = ch; upd_data = data;
        for (int i = 0; i < 8 && !done; i++) begin
            done = upd_ready;
            tick();
        end
        upd_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL upd_timeout ch%0d: upd_ready stayed 0, required 1", ch);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
        upd_valid = 1'b0; upd_ch = '0; upd_data = '0;
        repeat (3) tick();
        rst = 1'b1;

        // Reset state
        exp_sig("reset_ready", 1'b1, 1'b1);
        exp_sig("reset_irq", 1'b0, 1'b0);
        bus_read(4'd0,  16'h0030, "reset_ch0");
        bus_read(4'd9,  16'h0039, "reset_ch9");
        bus_read(4'd14, 16'h0000, "reset_status");
        bus_read(4'd15, 16'h0000, "reset_ctrl");
        bus_read(4'd12, 16'h0000, "unmapped_read");

        // Update then read; a 3-cycle rd clears fresh once
        update(4'd3, 8'hA5);
        bus_read(4'd14, 16'h0008, "fresh3_set");
        cs = 1'b1; rd = 1'b1; addr = 4'd3;
        repeat (3) begin
            exp_rd("ch3_long_read", 16'h00A5);
            tick();
        end
        cs = 1'b0; rd = 1'b0;
        tick();
        bus_read(4'd14, 16'h0000, "fresh3_cleared");
        // A held rd must not clear an update that lands during it
        cs = 1'b1; rd = 1'b1; addr = 4'd3;
        exp_rd("ch3_hold_c1", 16'h00A5);
        tick();
        upd_valid = 1'b1; upd_ch = 4'd3; upd_data = 8'h5A;
        exp_rd("ch3_hold_c2", 16'h00A5);
        tick();
        upd_valid = 1'b0;
        exp_rd("ch3_hold_c3", 16'h005A);
        tick();
        cs = 1'b0; rd = 1'b0;
        tick();
        bus_read(4'd14, 16'h0008, "fresh3_kept");
        bus_read(4'd3,  16'h005A, "ch3_read");
        bus_read(4'd14, 16'h0000, "fresh3_clear2");

        // Overrun and interrupt
        bus_write(4'd15, 16'h0008);
        update(4'd2, 8'h11);
        update(4'd2, 8'h22);
        exp_sig("irq_set", 1'b0, 1'b1);
        bus_read(4'd14, 16'h8004, "overrun_status");
        bus_read(4'd14, 16'h0004, "overrun_cleared");
        cs = 1'b1; rd = 1'b1; addr = 4'd2;
        exp_rd("ch2_read", 16'h0022);
        tick();
        cs = 1'b0; rd = 1'b0;
        exp_sig("irq_hold", 1'b0, 1'b1);
        tick();
        exp_sig("irq_drop", 1'b0, 1'b0);

        // Freeze snapshot
        bus_write(4'd15, 16'h0009);
        update(4'd5, 8'h77);
        bus_write(4'd15, 16'h0009);
        bus_read(4'd14, 16'h0020, "frozen_fresh5");
        bus_read(4'd5,  16'h0035, "frozen_ch5");
        bus_read(4'd15, 16'h0009, "ctrl_frozen");
        bus_write(4'd15, 16'h0008);
        bus_read(4'd5,  16'h0077, "thawed_ch5");

        // CPU write collides with sensor update
        bus_write(4'd15, 16'h000C);
        cs = 1'b1; wr = 1'b1; addr = 4'd4; d_in = 16'h1234;
        upd_valid = 1'b1; upd_ch = 4'd4; upd_data = 8'h99;
        exp_sig("collide_ready0", 1'b1, 1'b0);
        tick();
        wr = 1'b0; rd = 1'b1;
        exp_sig("collide_ready1", 1'b1, 1'b1);
        exp_rd("ch4_cpu", 16'h0034);
        tick();
        cs = 1'b0; rd = 1'b0; upd_valid = 1'b0;
        tick();
        bus_read(4'd4,  16'h0099, "ch4_upd");
        bus_read(4'd14, 16'h0000, "fresh4_cleared");
        update(4'd12, 8'hEE);
        bus_read(4'd14, 16'h4000, "bad_ch");
        bus_read(4'd9,  16'h0039, "ch9_untouched");
        bus_write(4'd15, 16'h0008);
        bus_write(4'd1,  16'hBEEF);
        bus_read(4'd1,  16'h0031, "wr_en0_ignored");

        // clr_all
        update(4'd6, 8'h66);
        cs = 1'b1; wr = 1'b1; addr = 4'd15; d_in = 16'h000A;
        exp_sig("clr_ready0", 1'b1, 1'b0);
        tick();
        cs = 1'b0; wr = 1'b0;
        tick();
        bus_read(4'd15, 16'h0008, "ctrl_after_clr");
        bus_read(4'd14, 16'h0000, "status_after_clr");
        bus_read(4'd6,  16'h0036, "ch6_after_clr");
        bus_read(4'd4,  16'h0034, "ch4_after_clr");

        // Reset during a held update
        rst = 1'b0;
        upd_valid = 1'b1; upd_ch = 4'd7; upd_data = 8'hC3;
        tick();
        tick();
        rst = 1'b1; upd_valid = 1'b0;
        exp_sig("rst_ready", 1'b1, 1'b1);
        exp_sig("rst_irq", 1'b0, 1'b0);
        bus_read(4'd7,  16'h0037, "ch7_not_written");
        bus_read(4'd14, 16'h0000, "status_after_rst");
        bus_read(4'd15, 16'h0000, "ctrl_after_rst");
        update(4'd7, 8'hC3);
        bus_read(4'd7,  16'h00C3, "ch7_represented");

        repeat (3) tick();
        checks++;
        if (rq.size() != 0 || sq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", rq.size() + sq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
